// File: rtl/rom_boot_loader_pkg.sv
// Shared definitions for the ROM boot loader: FSM states, ROM latency and header magic.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        COPY,
        DONE,
        ERROR
    } boot_state_e;

    localparam int          ROM_LATENCY   = 2;
    localparam int          MAGIC_LEN     = 4;
    localparam logic [31:0] DEFAULT_MAGIC = 32'h4D525341;

    // Header byte idx of the magic word, LSB first.
    function automatic logic [7:0] magic_byte(input logic [31:0] magic, input logic [1:0] idx);
        return magic[8*idx +: 8];
    endfunction

endpackage

// File: rtl/rom_boot_loader_if.sv
// Bus between the boot loader and its ROM, CPU RAM and CPU reset/status.
interface rom_boot_loader_if #(
    parameter int ROM_ADDR_W = 6,
    parameter int RAM_ADDR_W = 8
);
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic                  rom_enable_out;
    logic [7:0]            rom_data;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [7:0]            ram_data;
    logic                  ram_wr;
    logic                  cpu_reset;
    logic                  boot_done;
    logic                  boot_error;

    modport master (
        output rom_addr, rom_enable_out, ram_addr, ram_data, ram_wr,
        output cpu_reset, boot_done, boot_error,
        input  rom_data
    );

    modport slave (
        input  rom_addr, rom_enable_out, ram_addr, ram_data, ram_wr,
        input  cpu_reset, boot_done, boot_error,
        output rom_data
    );
endinterface

// File: rtl/rom_boot_loader_rom_read_pipe.sv
// Sequential ROM address issuer; tracks the registered-ROM latency and tags each
// returned byte with the index it was issued for.
module rom_read_pipe
    import boot_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [7:0]        rom_data_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              data_valid_o,
    output logic [ADDR_W-1:0] data_index_o,
    output logic [7:0]        data_byte_o
);

    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W:0]        cnt_q, cnt_d;
    logic                   active_q, active_d;
    logic [ROM_LATENCY-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0]      idx_q [ROM_LATENCY];
    logic [ADDR_W-1:0]      idx_d [ROM_LATENCY];
    logic                   issue;
    logic [ADDR_W-1:0]      issue_idx;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        issue     = 1'b0;
        issue_idx = cnt_q[ADDR_W-1:0];
        if (stop_i) begin
            active_d = 1'b0;
        end else if (start_i) begin
            issue     = 1'b1;
            issue_idx = '0;
            addr_d    = '0;
            cnt_d     = {{ADDR_W{1'b0}}, 1'b1};
            active_d  = 1'b1;
        end else if (active_q && (cnt_q < len_i)) begin
            // cnt_q is one bit wider than the address so a full-depth copy can end.
            issue  = 1'b1;
            addr_d = cnt_q[ADDR_W-1:0];
            cnt_d  = cnt_q + 1'b1;
        end
        vld_d    = stop_i ? '0 : {vld_q[ROM_LATENCY-2:0], issue};
        idx_d[0] = issue_idx;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            idx_d[i] = idx_q[i-1];
        end
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            vld_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            vld_q    <= vld_d;
        end
    end

    // NOTE: the index pipe is data only; vld_q qualifies it, so it is left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROM_LATENCY; i++) begin
            idx_q[i] <= idx_d[i];
        end
    end

    assign rom_addr_o   = addr_q;
    assign data_valid_o = vld_q[ROM_LATENCY-1];
    assign data_index_o = idx_q[ROM_LATENCY-1];
    assign data_byte_o  = rom_data_i;

endmodule

// File: rtl/rom_boot_loader.sv
// Checks the ROM magic header, copies COPY_LEN bytes into CPU RAM, then releases cpu_reset.
// DONE is reached at edge COPY_LEN+8 (first reset-low edge = edge 1), one edge before 1+6+COPY_LEN+2.
module rom_boot_loader
    import boot_pkg::*;
#(
    parameter int          ROM_ADDR_W = 6,
    parameter int          RAM_ADDR_W = 8,
    parameter int          COPY_LEN   = 64,
    parameter int          RAM_BASE   = 0,
    parameter logic [31:0] MAGIC      = DEFAULT_MAGIC
) (
    input logic             clk,
    input logic             reset,
    rom_boot_loader_if.master bus
);

    localparam logic [RAM_ADDR_W-1:0] BASE      = RAM_ADDR_W'(RAM_BASE);
    localparam logic [RAM_ADDR_W-1:0] LAST_ADDR = RAM_ADDR_W'(RAM_BASE + COPY_LEN - 1);
    localparam logic [ROM_ADDR_W:0]   COPY_LEN_W = (ROM_ADDR_W+1)'(COPY_LEN);
    localparam logic [ROM_ADDR_W:0]   HDR_LEN_W  = (ROM_ADDR_W+1)'(MAGIC_LEN);
    localparam logic [ROM_ADDR_W-1:0] HDR_LAST   = ROM_ADDR_W'(MAGIC_LEN - 1);

    boot_state_e           state_q, state_d;
    logic                  rom_en_q, rom_en_d;
    logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_data_q, ram_data_d;
    logic                  ram_wr_q, ram_wr_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  boot_done_q, boot_done_d;
    logic                  boot_error_q, boot_error_d;

    logic                  pipe_start, pipe_stop;
    logic                  data_valid;
    logic [ROM_ADDR_W-1:0] data_index;
    logic [7:0]            data_byte;

    rom_read_pipe #(.ADDR_W(ROM_ADDR_W)) u_pipe (
        .clk          (clk),
        .reset        (reset),
        .start_i      (pipe_start),
        .stop_i       (pipe_stop),
        .len_i        ((state_q == COPY) ? COPY_LEN_W : HDR_LEN_W),
        .rom_data_i   (bus.rom_data),
        .rom_addr_o   (bus.rom_addr),
        .data_valid_o (data_valid),
        .data_index_o (data_index),
        .data_byte_o  (data_byte)
    );

    always_comb begin
        state_d      = state_q;
        rom_en_d     = rom_en_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        ram_wr_d     = 1'b0;
        cpu_reset_d  = cpu_reset_q;
        boot_done_d  = boot_done_q;
        boot_error_d = boot_error_q;
        pipe_start   = 1'b0;
        pipe_stop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d    = CHECK;
                rom_en_d   = 1'b1;
                pipe_start = 1'b1;
            end
            CHECK: begin
                if (data_valid) begin
                    if (data_byte != magic_byte(MAGIC, data_index[1:0])) begin
                        state_d      = ERROR;
                        rom_en_d     = 1'b0;
                        boot_error_d = 1'b1;
                        pipe_stop    = 1'b1;
                    end else if (data_index == HDR_LAST) begin
                        state_d    = COPY;
                        pipe_start = 1'b1;
                    end
                end
            end
            COPY: begin
                if (data_valid) begin
                    ram_wr_d   = 1'b1;
                    ram_addr_d = BASE + RAM_ADDR_W'(data_index);
                    ram_data_d = data_byte;
                end else if (ram_wr_q && (ram_addr_q == LAST_ADDR)) begin
                    state_d     = DONE;
                    rom_en_d    = 1'b0;
                    cpu_reset_d = 1'b0;
                    boot_done_d = 1'b1;
                    pipe_stop   = 1'b1;
                end
            end
            default: pipe_stop = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rom_en_q     <= 1'b0;
            ram_addr_q   <= BASE;
            ram_data_q   <= 8'h00;
            ram_wr_q     <= 1'b0;
            cpu_reset_q  <= 1'b1;
            boot_done_q  <= 1'b0;
            boot_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_en_q     <= rom_en_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_wr_q     <= ram_wr_d;
            cpu_reset_q  <= cpu_reset_d;
            boot_done_q  <= boot_done_d;
            boot_error_q <= boot_error_d;
        end
    end

    assign bus.rom_enable_out = rom_en_q;
    assign bus.ram_addr       = ram_addr_q;
    assign bus.ram_data       = ram_data_q;
    // Gated so a write already registered cannot land while reset is held.
    assign bus.ram_wr         = ram_wr_q & ~reset;
    assign bus.cpu_reset      = cpu_reset_q;
    assign bus.boot_done      = boot_done_q;
    assign bus.boot_error     = boot_error_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Randomized self-checking bench: two loader configurations against a ROM/RAM model and
// expectations computed from the header/copy rules and fixed ROM latency.
module tb_rom_boot_loader;

    localparam int A_LEN  = 64;
    localparam int A_BASE = 0;
    localparam int B_LEN  = 16;
    localparam int B_BASE = 8'h80;

    typedef struct packed {
        logic [5:0] rom_addr;
        logic       en;
        logic [7:0] ram_addr;
        logic [7:0] ram_data;
        logic       wr;
        logic       cpu_rst;
        logic       done;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] magic_b [4] = '{8'h41, 8'h53, 8'h52, 8'h4D};
    logic [7:0] rom_a [64];
    logic [7:0] rom_b [64];
    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];

    always #5 clk = ~clk;

    rom_boot_loader_if #(.ROM_ADDR_W(6), .RAM_ADDR_W(8)) bus_a ();
    rom_boot_loader_if #(.ROM_ADDR_W(6), .RAM_ADDR_W(8)) bus_b ();

    rom_boot_loader #(.ROM_ADDR_W(6), .RAM_ADDR_W(8), .COPY_LEN(A_LEN), .RAM_BASE(A_BASE),
                      .MAGIC(32'h4D525341))
        dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));

    rom_boot_loader #(.ROM_ADDR_W(6), .RAM_ADDR_W(8), .COPY_LEN(B_LEN), .RAM_BASE(B_BASE),
                      .MAGIC(32'h4D525341))
        dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

    // Registered ROM (drives 0 while disabled) and byte-wide RAM.
    always @(posedge clk) begin
        bus_a.rom_data <= bus_a.rom_enable_out ? rom_a[bus_a.rom_addr] : 8'h00;
        bus_b.rom_data <= bus_b.rom_enable_out ? rom_b[bus_b.rom_addr] : 8'h00;
        if (bus_a.ram_wr) ram_a[bus_a.ram_addr] <= bus_a.ram_data;
        if (bus_b.ram_wr) ram_b[bus_b.ram_addr] <= bus_b.ram_data;
    end

    obs_t obs_a, obs_b;
    assign obs_a = '{rom_addr: bus_a.rom_addr, en: bus_a.rom_enable_out, ram_addr: bus_a.ram_addr,
                     ram_data: bus_a.ram_data, wr: bus_a.ram_wr, cpu_rst: bus_a.cpu_reset,
                     done: bus_a.boot_done, err: bus_a.boot_error};
    assign obs_b = '{rom_addr: bus_b.rom_addr, en: bus_b.rom_enable_out, ram_addr: bus_b.ram_addr,
                     ram_data: bus_b.ram_data, wr: bus_b.ram_wr, cpu_rst: bus_b.cpu_reset,
                     done: bus_b.boot_done, err: bus_b.boot_error};

    function automatic obs_t get_obs(input bit sel);
        return sel ? obs_b : obs_a;
    endfunction

    function automatic obs_t reset_obs(input bit sel);
        obs_t o;
        o = '{rom_addr: 6'd0, en: 1'b0, ram_addr: (sel ? 8'h80 : 8'h00), ram_data: 8'h00,
              wr: 1'b0, cpu_rst: 1'b1, done: 1'b0, err: 1'b0};
        return o;
    endfunction

    function automatic logic [7:0] rom_byte(input bit sel, input int i);
        return sel ? rom_b[i[5:0]] : rom_a[i[5:0]];
    endfunction

    task automatic set_reset(input bit sel, input logic v);
        if (sel) reset_b = v;
        else     reset_a = v;
    endtask

    // Valid header, body either addr^0xA5 or random.
    task automatic fill_rom(input bit sel, input bit random_body);
        logic [7:0] b;
        for (int i = 0; i < 64; i++) begin
            if (i < 4)            b = magic_b[i];
            else if (random_body) b = 8'($urandom_range(0, 255));
            else                  b = 8'(i) ^ 8'hA5;
            if (sel) rom_b[i] = b;
            else     rom_a[i] = b;
        end
    endtask

    // Called at a negedge; holds reset for n cycles checking every output each cycle.
    task automatic hold_reset(input bit sel, input int n, input string tag);
        set_reset(sel, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (get_obs(sel) !== reset_obs(sel)) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs %h, required %h", tag, i, get_obs(sel), reset_obs(sel));
            end
        end
    endtask

    // Releases reset at a negedge and observes every cycle (edge 1 = first reset-low edge).
    task automatic run_boot(input bit sel, input int abort_at, input string tag,
                            output int done_edge, output int err_edge, output int n_wr,
                            output int max_rom_addr);
        int   len;
        int   base;
        int   tail;
        bit   fin;
        obs_t o;
        len          = sel ? B_LEN : A_LEN;
        base         = sel ? B_BASE : A_BASE;
        done_edge    = -1;
        err_edge     = -1;
        n_wr         = 0;
        max_rom_addr = 0;
        tail         = -1;
        fin          = 1'b0;
        set_reset(sel, 1'b0);
        for (int cyc = 1; cyc <= len + 40 && !fin; cyc++) begin
            @(negedge clk);
            o = get_obs(sel);
            if (int'(o.rom_addr) > max_rom_addr) max_rom_addr = int'(o.rom_addr);
            if (cyc == 1) begin
                checks++;
                if (o.en !== 1'b1 || o.rom_addr !== 6'd0) begin
                    errors++;
                    $display("FAIL %s first_edge: en=%b addr=%0d, required en=1 addr=0", tag, o.en, o.rom_addr);
                end
            end
            if (o.wr === 1'b1) begin
                checks++;
                if (n_wr >= len || o.ram_addr !== 8'(base + n_wr) ||
                    o.ram_data !== rom_byte(sel, n_wr) || o.en !== 1'b1) begin
                    errors++;
                    $display("FAIL %s write %0d: addr=%h data=%h en=%b, required addr=%h data=%h en=1 (len %0d)",
                             tag, n_wr, o.ram_addr, o.ram_data, o.en, 8'(base + n_wr),
                             rom_byte(sel, n_wr), len);
                end
                n_wr++;
                if (n_wr == abort_at) return;
            end
            checks++;
            if ((o.done & o.err) !== 1'b0 || o.cpu_rst !== ~o.done) begin
                errors++;
                $display("FAIL %s status cycle %0d: done=%b err=%b cpu_reset=%b", tag, cyc, o.done, o.err, o.cpu_rst);
            end
            if (o.done === 1'b1 && done_edge < 0) done_edge = cyc;
            if (o.err === 1'b1 && err_edge < 0)   err_edge  = cyc;
            if ((o.done === 1'b1 || o.err === 1'b1) && tail < 0) tail = 4;
            if (tail >= 0) begin
                checks++;
                if (o.en !== 1'b0 || o.wr !== 1'b0) begin
                    errors++;
                    $display("FAIL %s terminal cycle %0d: en=%b wr=%b, required 0 0", tag, cyc, o.en, o.wr);
                end
                if (tail == 0) fin = 1'b1;
                tail--;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done/error within %0d cycles", tag, len + 40);
        end
    endtask

    task automatic check_ram(input bit sel, input string tag);
        int bad = 0;
        int len  = sel ? B_LEN : A_LEN;
        int base = sel ? B_BASE : A_BASE;
        logic [7:0] got;
        for (int i = 0; i < len; i++) begin
            got = sel ? ram_b[8'(base + i)] : ram_a[8'(base + i)];
            if (got !== rom_byte(sel, i)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s ram_image: %0d bytes differ from ROM, required 0", tag, bad);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", tag, got, want);
        end
    endtask

    task automatic test_reset();
        fill_rom(1'b0, 1'b0);
        hold_reset(1'b0, 10, "reset_a");
        hold_reset(1'b1, 2, "reset_b");
    endtask

    task automatic test_valid_image(output int lat);
        int d, e, n, m, d2;
        fill_rom(1'b0, 1'b0);
        run_boot(1'b0, -1, "valid1", d, e, n, m);
        expect_int("valid1_done_edge", d, A_LEN + 8);
        expect_int("valid1_writes", n, A_LEN);
        expect_int("valid1_no_error", e, -1);
        check_ram(1'b0, "valid1");
        hold_reset(1'b0, 2, "valid_rst");
        run_boot(1'b0, -1, "valid2", d2, e, n, m);
        expect_int("valid_latency_repeat", d2, d);
        expect_int("valid2_writes", n, A_LEN);
        lat = d;
    endtask

    task automatic test_bad_magic();
        int d, e, n, m, k;
        obs_t o;
        for (int t = 0; t < 5; t++) begin
            fill_rom(1'b0, 1'b1);
            k = (t == 0) ? 2 : int'($urandom_range(0, 3));
            rom_a[k] = (t == 0) ? 8'h00 : (magic_b[k] ^ 8'(1 << $urandom_range(0, 7)));
            hold_reset(1'b0, 2, "bad_rst");
            run_boot(1'b0, -1, "bad", d, e, n, m);
            expect_int("bad_error_edge", e, 3 + k);
            expect_int("bad_writes", n, 0);
            expect_int("bad_no_done", d, -1);
            o = get_obs(1'b0);
            checks++;
            if (o.cpu_rst !== 1'b1 || o.err !== 1'b1 || o.en !== 1'b0) begin
                errors++;
                $display("FAIL bad_final: cpu_reset=%b err=%b en=%b, required 1 1 0", o.cpu_rst, o.err, o.en);
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        int d, e, n, m;
        fill_rom(1'b0, 1'b1);
        hold_reset(1'b0, 2, "mid_rst0");
        run_boot(1'b0, 20, "mid_abort", d, e, n, m);
        expect_int("mid_abort_writes", n, 20);
        set_reset(1'b0, 1'b1);
        #1;
        expect_int("mid_wr_gated", int'(bus_a.ram_wr), 0);
        hold_reset(1'b0, 3, "mid_rst");
        run_boot(1'b0, -1, "mid_restart", d, e, n, m);
        expect_int("mid_restart_writes", n, A_LEN);
        expect_int("mid_restart_done_edge", d, A_LEN + 8);
        check_ram(1'b0, "mid_restart");
    endtask

    task automatic test_window();
        int d, e, n, m;
        fill_rom(1'b1, 1'b1);
        hold_reset(1'b1, 2, "win_rst");
        run_boot(1'b1, -1, "window", d, e, n, m);
        expect_int("window_writes", n, B_LEN);
        expect_int("window_done_edge", d, B_LEN + 8);
        checks++;
        if (m > B_LEN - 1) begin
            errors++;
            $display("FAIL window_rom_addr: max %0d, required <= %0d", m, B_LEN - 1);
        end
        check_ram(1'b1, "window");
    endtask

    task automatic test_long_reset(input int lat);
        int d, e, n, m;
        fill_rom(1'b0, 1'b0);
        hold_reset(1'b0, 10, "long_rst");
        run_boot(1'b0, -1, "long", d, e, n, m);
        expect_int("long_latency", d, lat);
        expect_int("long_writes", n, A_LEN);
        check_ram(1'b0, "long");
    endtask

    initial begin
        int lat;
        reset_a = 1'b1;
        reset_b = 1'b1;
        test_reset();
        test_valid_image(lat);
        test_bad_magic();
        test_reset_mid_copy();
        test_window();
        test_long_reset(lat);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_boot_loader.md
Name: rom_boot_loader

Overview:
- Sits directly downstream of the synchronous program ROM. It consumes the ROM's registered byte output and copies the program image into the CPU's RAM.
- Before copying, it checks the 4-byte "ASRM" magic header.
- It holds the CPU in reset until the copy completes. On a bad header it latches an error flag and keeps the CPU in reset.

Parameters:
- ROM_ADDR_W, 6, ROM address width; ROM depth = 2**ROM_ADDR_W.
- RAM_ADDR_W, 8, RAM write address width.
- COPY_LEN, 64, bytes copied from ROM address 0. Legal range: 4..2**ROM_ADDR_W.
- RAM_BASE, 0, RAM address receiving ROM byte 0. RAM_BASE+COPY_LEN must be ≤ 2**RAM_ADDR_W.
- MAGIC, 32'h4D525341, expected bytes at ROM 0..3, LSB first: 0x41, 0x53, 0x52, 0x4D.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- rom_addr  out  ROM_ADDR_W  ROM read address (registered).
- rom_enable_out  out  1  ROM output enable; ROM drives 0 when low.
- rom_data  in  8  ROM data; valid on the second edge after rom_addr changes.
- ram_addr  out  RAM_ADDR_W  RAM write address (registered).
- ram_data  out  8  RAM write data (registered).
- ram_wr  out  1  RAM write strobe; one byte per cycle while high.
- cpu_reset  out  1  reset to the CPU; high until the boot succeeds.
- boot_done  out  1  sticky; copy finished successfully.
- boot_error  out  1  sticky; magic header mismatch.

Behaviour:
- Reset values while reset=1:
  - state=IDLE
  - rom_addr=0, rom_enable_out=0
  - ram_addr=RAM_BASE, ram_data=0, ram_wr=0
  - cpu_reset=1, boot_done=0, boot_error=0
- Reset asserted at any point, including mid-CHECK or mid-COPY, aborts the run. No ram_wr pulse occurs in a cycle where reset=1.
- ROM latency model:
  - rom_addr driven from edge t is captured by the ROM at edge t+1.
  - The loader samples rom_data at edge t+2.
  - The loader keeps a 2-deep valid/index pipeline tracking issued addresses.
- IDLE -> CHECK at the first edge with reset=0. At that edge: rom_enable_out=1, rom_addr=0.
- CHECK:
  - Issues addresses 0,1,2,3 on consecutive cycles, then holds rom_addr.
  - Compares each returned byte against MAGIC[8i+7:8i].
  - ram_wr stays 0 throughout.
  - Any mismatch -> ERROR at the sampling edge.
  - All four match -> COPY at the edge sampling byte 3. That same edge sets rom_addr=0.
- COPY:
  - Issues addresses 0..COPY_LEN-1, one per cycle.
  - Each returned byte index i produces ram_wr=1, ram_addr=RAM_BASE+i, ram_data=byte, asserted from the sampling edge.
  - Writes are exactly COPY_LEN, on consecutive cycles, with no gaps or duplicates.
  - rom_addr must not wrap past COPY_LEN-1. After the last issue it holds and stops advancing.
- DONE:
  - Entered at the edge following the last write.
  - At that edge: ram_wr=0, rom_enable_out=0, cpu_reset=0, boot_done=1.
  - Terminal until reset.
- ERROR:
  - rom_enable_out=0, ram_wr=0, cpu_reset=1, boot_error=1.
  - Terminal until reset.
- boot_done and boot_error are never both 1.
- Latency from the first reset-low edge: DONE reached at edge 1+6+COPY_LEN+2 (±1 allowed only if documented in the RTL header). It must be identical across runs.
- Address arithmetic is modulo 2**RAM_ADDR_W; the parameter check makes overflow impossible.
- COPY_LEN=2**ROM_ADDR_W: the final issue is the all-ones address. The issue counter must be ROM_ADDR_W+1 bits to detect the end.

Decomposition:
- Shared package (boot_pkg):
  - state encoding: IDLE, CHECK, COPY, DONE, ERROR
  - ROM_LATENCY=2
  - default MAGIC constant
- Natural sub-module: rom_read_pipe. It issues sequential addresses, tracks the 2-cycle latency, and emits data_valid/data_index/data_byte to the FSM. It is reused by both CHECK and COPY.

Test Plan:
- Valid image: ROM 0..3 = 41 53 52 4D, rest = addr^0xA5 -> exactly 64 consecutive writes with ram[i]=rom[i]; boot_done=1; cpu_reset falls; latency constant across two runs.
- Bad magic: ROM[2]=0x00 -> boot_error=1 at the byte-2 sampling edge; zero ram_wr pulses; cpu_reset stays 1; rom_enable_out=0 afterwards.
- Reset mid-COPY after the 20th write -> ram_wr=0 during reset; full restart gives 64 fresh writes starting at RAM_BASE; final RAM matches ROM.
- RAM_BASE=0x80, COPY_LEN=16 -> writes only to 0x80..0x8F; no write outside that range; rom_addr never exceeds 0x0F.
- Enable gating: scoreboard checks rom_enable_out=1 on every edge where a sampled byte is used; in IDLE/DONE/ERROR the model returns 0 and there is no ram_wr.
- Reset held high for 10 cycles, then released -> all outputs hold reset values; same behaviour and latency as the first scenario.
